// File: rtl/qsim_pkg.sv
// qsim_pkg: shared definitions for the qsim datapath.
//   DWIDTH  default operand width (dividend/quotient are 2*DWIDTH wide)
//   QWIDTH  product/quotient width at the default operand width
//   QMAX    most-positive signed QWIDTH value, used for saturation
//   QMIN    most-negative signed QWIDTH value, used for saturation
//   state_e sequencer states of the iterative divider
package qsim_pkg;

  localparam int unsigned DWIDTH = 8;
  localparam int unsigned QWIDTH = 2 * DWIDTH;

  localparam logic [QWIDTH-1:0] QMAX = {1'b0, {(QWIDTH-1){1'b1}}};
  localparam logic [QWIDTH-1:0] QMIN = {1'b1, {(QWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2
  } state_e;

endpackage

// File: rtl/qdiv_step.sv
// qdiv_step: one combinational radix-2 restoring division stage on magnitudes.
//   rem_i  partial remainder (always < dvs_i when dvs_i != 0)
//   quo_i  dividend bits not yet consumed / quotient bits produced so far
//   dvs_i  divisor magnitude
//   rem_o  next partial remainder
//   quo_o  quo_i shifted left with the new quotient bit in the LSB
module qdiv_step #(
  parameter int unsigned DWIDTH = 8
) (
  input  logic [DWIDTH-1:0]   rem_i,
  input  logic [2*DWIDTH-1:0] quo_i,
  input  logic [DWIDTH-1:0]   dvs_i,
  output logic [DWIDTH-1:0]   rem_o,
  output logic [2*DWIDTH-1:0] quo_o
);

  // One bit wider than the remainder: 2*rem+1 can exceed DWIDTH bits.
  logic [DWIDTH:0] shifted;

  assign shifted = {rem_i, quo_i[2*DWIDTH-1]};

  always_comb begin
    if (shifted >= {1'b0, dvs_i}) begin
      // The difference is below dvs_i, so it fits back in DWIDTH bits.
      rem_o = shifted[DWIDTH-1:0] - dvs_i;
      quo_o = {quo_i[2*DWIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[DWIDTH-1:0];
      quo_o = {quo_i[2*DWIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/qdiv_seq.sv
// qdiv_seq: sequential signed restoring divider, one quotient bit per clock.
//   i_clk, i_rst        clock (rising edge), synchronous active-high reset
//   i_start             request, accepted only while o_busy is low
//   i_dividend          2*DWIDTH signed dividend, sampled on the accept edge
//   i_divisor           DWIDTH signed divisor, sampled on the accept edge
//   o_busy              high from after the accept edge through the fix-up edge
//   o_valid             one-cycle pulse when the result registers update
//   o_quotient          2*DWIDTH signed quotient, truncated toward zero
//   o_remainder         DWIDTH signed remainder with the dividend's sign
//   o_dbz, o_ovf        divide-by-zero / overflow flags for the current result
module qdiv_seq #(
  parameter int unsigned DWIDTH = qsim_pkg::DWIDTH
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [2*DWIDTH-1:0] i_dividend,
  input  logic [DWIDTH-1:0]   i_divisor,
  output logic                o_busy,
  output logic                o_valid,
  output logic [2*DWIDTH-1:0] o_quotient,
  output logic [DWIDTH-1:0]   o_remainder,
  output logic                o_dbz,
  output logic                o_ovf
);

  import qsim_pkg::*;

  localparam int unsigned QW = 2 * DWIDTH;
  localparam int unsigned CW = $clog2(QW);

  // Saturation values at this instance's width.
  localparam logic [QW-1:0] SatMax = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0] SatMin = {1'b1, {(QW-1){1'b0}}};

  state_e          state_q;
  logic [CW-1:0]   count_q;
  logic [DWIDTH-1:0] rem_q;
  logic [DWIDTH-1:0] dvs_q;
  logic [QW-1:0]   quo_q;
  logic            dd_neg_q;
  logic            dv_neg_q;

  logic [DWIDTH-1:0] rem_step;
  logic [QW-1:0]     quo_step;
  logic [QW-1:0]     dd_mag;
  logic [DWIDTH-1:0] dv_mag;
  logic              q_neg;

  // Unsigned magnitudes: the most-negative input maps to 2^(W-1), which
  // still fits because the magnitude is held unsigned.
  assign dd_mag = i_dividend[QW-1]    ? -i_dividend : i_dividend;
  assign dv_mag = i_divisor[DWIDTH-1] ? -i_divisor  : i_divisor;
  assign q_neg  = dd_neg_q ^ dv_neg_q;

  qdiv_step #(
    .DWIDTH(DWIDTH)
  ) u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .dvs_i(dvs_q),
    .rem_o(rem_step),
    .quo_o(quo_step)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      dd_neg_q    <= 1'b0;
      dv_neg_q    <= 1'b0;
      o_busy      <= 1'b0;
      o_valid     <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
      o_dbz       <= 1'b0;
      o_ovf       <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            quo_q    <= dd_mag;
            rem_q    <= '0;
            dvs_q    <= dv_mag;
            dd_neg_q <= i_dividend[QW-1];
            dv_neg_q <= i_divisor[DWIDTH-1];
            count_q  <= '0;
            o_busy   <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          rem_q   <= rem_step;
          quo_q   <= quo_step;
          count_q <= count_q + CW'(1);
          if (count_q == CW'(QW - 1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          o_busy  <= 1'b0;
          o_valid <= 1'b1;
          state_q <= StIdle;
          if (dvs_q == '0) begin
            o_quotient  <= dd_neg_q ? SatMin : SatMax;
            o_remainder <= '0;
            o_dbz       <= 1'b1;
            o_ovf       <= 1'b0;
          end else if (!q_neg && quo_q == SatMin) begin
            // Only most-negative / -1 yields a positive magnitude of 2^(QW-1).
            o_quotient  <= SatMax;
            o_remainder <= '0;
            o_dbz       <= 1'b0;
            o_ovf       <= 1'b1;
          end else begin
            o_quotient  <= q_neg ? -quo_q : quo_q;
            o_remainder <= dd_neg_q ? -rem_q : rem_q;
            o_dbz       <= 1'b0;
            o_ovf       <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_qdiv_seq.sv
module tb_qdiv_seq;

  logic        clk;
  logic        i_rst;
  logic        i_start;
  logic [15:0] i_dividend;
  logic [7:0]  i_divisor;
  logic        o_busy;
  logic        o_valid;
  logic [15:0] o_quotient;
  logic [7:0]  o_remainder;
  logic        o_dbz;
  logic        o_ovf;

  int n_vec = 0;
  int n_bad = 0;

  qdiv_seq #(
    .DWIDTH(8)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .o_busy     (o_busy),
    .o_valid    (o_valid),
    .o_quotient (o_quotient),
    .o_remainder(o_remainder),
    .o_dbz      (o_dbz),
    .o_ovf      (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered at the falling edge just after the accept edge (lat = 1).
  task automatic wait_valid(output int lat, output int bcnt);
    lat  = 1;
    bcnt = 0;
    while (!o_valid && lat < 40) begin
      if (o_busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_div(input logic [15:0] a, input logic [7:0] b,
                         output int lat, output int bcnt);
    @(negedge clk);
    i_dividend = a;
    i_divisor  = b;
    i_start    = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_valid(lat, bcnt);
  endtask

  task automatic expect_res(input string tag, input logic [15:0] q, input logic [7:0] r,
                            input logic dbz, input logic ovf);
    check({tag, ".q"},   32'(o_quotient),  32'(q));
    check({tag, ".r"},   32'(o_remainder), 32'(r));
    check({tag, ".dbz"}, 32'(o_dbz),       32'(dbz));
    check({tag, ".ovf"}, 32'(o_ovf),       32'(ovf));
  endtask

  task automatic dir(input string tag, input logic [15:0] a, input logic [7:0] b,
                     input logic [15:0] q, input logic [7:0] r, input logic dbz, input logic ovf);
    int lat;
    int bcnt;
    run_div(a, b, lat, bcnt);
    check({tag, ".lat"}, 32'(lat), 32'd18);
    expect_res(tag, q, r, dbz, ovf);
  endtask

  function automatic void ref_div(input logic signed [15:0] a, input logic signed [7:0] b,
                                  output logic [15:0] q, output logic [7:0] r,
                                  output logic dbz, output logic ovf);
    int ai;
    int bi;
    ai  = a;
    bi  = b;
    dbz = 1'b0;
    ovf = 1'b0;
    if (bi == 0) begin
      dbz = 1'b1;
      q   = (ai >= 0) ? 16'h7fff : 16'h8000;
      r   = 8'h00;
    end else if (ai == -32768 && bi == -1) begin
      ovf = 1'b1;
      q   = 16'h7fff;
      r   = 8'h00;
    end else begin
      q = 16'(ai / bi);
      r = 8'(ai % bi);
    end
  endfunction

  initial begin
    int lat;
    int bcnt;
    int pulses;
    logic signed [15:0] ra;
    logic signed [7:0]  rb;
    logic [15:0] eq;
    logic [7:0]  er;
    logic edbz;
    logic eovf;

    i_rst      = 1'b1;
    i_start    = 1'b0;
    i_dividend = '0;
    i_divisor  = '0;
    repeat (2) @(negedge clk);
    check("rst.busy",  32'(o_busy),  32'd0);
    check("rst.valid", 32'(o_valid), 32'd0);
    expect_res("rst", 16'h0000, 8'h00, 1'b0, 1'b0);

    // Reset and start in the same cycle: reset wins.
    i_start    = 1'b1;
    i_dividend = 16'd40;
    i_divisor  = 8'd4;
    @(negedge clk);
    check("rst_start.busy", 32'(o_busy), 32'd0);
    i_rst   = 1'b0;
    i_start = 1'b0;
    @(negedge clk);
    check("rst_start.busy2", 32'(o_busy), 32'd0);

    // Latency and busy window.
    run_div(16'd16129, 8'd127, lat, bcnt);
    check("sq.lat",  32'(lat),  32'd18);
    check("sq.busy", 32'(bcnt), 32'd17);
    expect_res("sq", 16'd127, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("sq.pulse", 32'(o_valid),    32'd0);
    check("sq.hold",  32'(o_quotient), 32'd127);

    dir("p_n",   16'd7,      8'hfe, 16'hfffd, 8'h01, 1'b0, 1'b0);
    dir("n_p",   16'hfff9,   8'd2,  16'hfffd, 8'hff, 1'b0, 1'b0);
    dir("n127",  16'hc080,   8'd127, 16'hff80, 8'h00, 1'b0, 1'b0);
    dir("m1_1",  16'hffff,   8'd1,  16'hffff, 8'h00, 1'b0, 1'b0);
    dir("dbz_p", 16'd100,    8'd0,  16'h7fff, 8'h00, 1'b1, 1'b0);
    dir("dbz_n", 16'hfffb,   8'd0,  16'h8000, 8'h00, 1'b1, 1'b0);
    dir("clr",   16'd6,      8'd3,  16'd2,    8'h00, 1'b0, 1'b0);
    dir("ovf",   16'h8000,   8'hff, 16'h7fff, 8'h00, 1'b0, 1'b1);
    dir("min_1", 16'h8000,   8'd1,  16'h8000, 8'h00, 1'b0, 1'b0);

    // Start while busy is ignored.
    @(negedge clk);
    i_dividend = 16'd50;
    i_divisor  = 8'd5;
    i_start    = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (4) @(negedge clk);
    i_dividend = 16'd9;
    i_divisor  = 8'd3;
    i_start    = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_valid(lat, bcnt);
    check("ign.valid", 32'(o_valid), 32'd1);
    expect_res("ign", 16'd10, 8'd0, 1'b0, 1'b0);

    // Back-to-back start in the valid cycle.
    i_dividend = 16'd9;
    i_divisor  = 8'd3;
    i_start    = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("b2b.busy", 32'(o_busy),     32'd1);
    check("b2b.hold", 32'(o_quotient), 32'd10);
    wait_valid(lat, bcnt);
    check("b2b.lat", 32'(lat), 32'd18);
    expect_res("b2b", 16'd3, 8'd0, 1'b0, 1'b0);

    // Reset mid-operation.
    @(negedge clk);
    i_dividend = 16'd1000;
    i_divisor  = 8'd7;
    i_start    = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (6) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    check("abort.busy",  32'(o_busy),  32'd0);
    check("abort.valid", 32'(o_valid), 32'd0);
    expect_res("abort", 16'h0000, 8'h00, 1'b0, 1'b0);
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (o_valid) pulses++;
    end
    check("abort.pulses", 32'(pulses), 32'd0);
    dir("after", 16'd14, 8'd7, 16'd2, 8'd0, 1'b0, 1'b0);

    // Random pairs against the reference model; stop at the first miscompare.
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = 8'($urandom);
      if (i % 40 == 7) rb = 8'sd0;
      if (i % 23 == 5) ra = 16'($urandom_range(0, 255)) - 16'sd128;
      if (i == 123) begin
        ra = 16'sh8000;
        rb = -8'sd1;
      end
      ref_div(ra, rb, eq, er, edbz, eovf);
      run_div(ra, rb, lat, bcnt);
      check($sformatf("rnd%0d.lat", i), 32'(lat), 32'd18);
      expect_res($sformatf("rnd%0d(%0d/%0d)", i, ra, rb), eq, er, edbz, eovf);
      if (n_bad != 0) break;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
